inst_sequencer: RTL and testbench
=================================

Name: inst_sequencer

Overview:
- Timing and sequencing counterpart of the 6502 instruction decoder.
- Owns the instruction register and the T-cycle counter, and consumes the decoder's icyc/rcyc/scyc/sinst requests.
- Latches reset, NMI and IRQ requests and forces the BRK/interrupt opcode (8'h00) into the instruction register at instruction boundaries.
- Feeds inst, cycle, clr, nmi and irq back into the decoder.

Parameters:
- DATA_W, 8, opcode/data-bus width.
- CYC_W, 3, cycle counter width; counts 0..2^CYC_W-1.
- INT_OPC, 8'h00, opcode forced on reset/NMI/IRQ entry.
- NMI_SYNC, 2, number of synchroniser flops on nmi_in (minimum 1).

Ports:
- clk  in  1  system clock.
- clr  in  1  synchronous active-high reset.
- din  in  DATA_W  opcode from the input data latch, sampled on rcyc.
- icyc  in  1  decoder request: advance the cycle counter.
- rcyc  in  1  decoder request: end of instruction; cycle to 0 and load the next opcode.
- scyc  in  1  stall; hold inst and cycle this clock.
- sinst  in  1  decoder acknowledge that interrupt/reset entry has been taken.
- irq_in  in  1  level IRQ request, active high.
- nmi_in  in  1  NMI request; rising edge is latched.
- irq_dis  in  1  status I flag; masks IRQ.
- inst  out  DATA_W  current opcode to the decoder.
- cycle  out  CYC_W  current T-cycle to the decoder.
- rst_pend  out  1  drives the decoder's clr.
- nmi_pend  out  1  drives the decoder's nmi.
- irq_req  out  1  drives the decoder's irq; equals irq_in & ~irq_dis, registered.
- seq_err  out  1  sticky: icyc at terminal cycle count.

Behaviour:
- Reset is synchronous: while clr=1 at a clk edge:
  - inst=INT_OPC, cycle=0, rst_pend=1.
  - nmi_pend=0, irq_req=0, seq_err=0, synchroniser flops cleared.
- Request priority each clock: scyc > rcyc > icyc. Only the highest-priority asserted request acts.
- scyc: inst and cycle hold. Interrupt latching (nmi edge, irq_req update) still runs.
- rcyc:
  - cycle <= 0.
  - If rst_pend | nmi_pend | irq_req (values before this edge), inst <= INT_OPC; otherwise inst <= din.
- icyc: cycle <= cycle+1. If cycle = 2^CYC_W-1, cycle wraps to 0, seq_err <= 1 (sticky until clr), and inst holds.
- No request: everything holds.
- sinst clears exactly one source, the highest-priority one pending: rst_pend, else nmi_pend. irq_req is level and is never cleared by sinst.
- NMI:
  - nmi_in passes through NMI_SYNC flops. A 0->1 transition at the synchroniser output sets nmi_pend.
  - If set and clear (sinst with rst_pend=0) occur on the same clock, set wins; nmi_pend stays 1.
- irq_req is re-registered every clock (including during scyc), 1-clock latency from irq_in/irq_dis.
- Latency: all outputs are registered. A request sampled at edge N is visible after edge N.
- Reset mid-instruction: abandons the instruction immediately; the next cycle is 0 with INT_OPC and rst_pend=1.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- When defined, adds ports step_mode (in, 1), step_req (in, 1), and halted (out, 1).
- With step_mode=1, an rcyc is not executed until a step_req pulse is seen:
  - halted=1; inst and cycle hold; the decoder keeps asserting rcyc.
  - On a clock with rcyc & step_req, the normal rcyc action occurs and halted=0.
  - step_req without rcyc is ignored; it is not queued.
- With step_mode=0, behaviour is identical to the macro-undefined build.
- halted resets to 0.
- When undefined: no extra ports; rcyc always acts immediately.

Test Plan:
- Reset: clr high 1 clock, then low -> inst=8'h00, cycle=0, rst_pend=1. A sinst pulse -> rst_pend=0. Three icyc -> cycle=3. rcyc with din=8'hA9 -> inst=8'hA9, cycle=0.
- Opcode fetch: din=8'h6D; rcyc then 4 icyc then rcyc with din=8'hEA -> cycle sequence 0,1,2,3,4,0; inst 8'h6D then 8'hEA.
- NMI vs IRQ priority:
  - irq_in=1, irq_dis=0, nmi_in rising -> after the sync delay nmi_pend=1, irq_req=1.
  - rcyc -> inst=8'h00. sinst -> nmi_pend=0, irq_req stays 1.
  - Next rcyc -> inst=8'h00 again.
- IRQ masked: irq_in=1, irq_dis=1, rcyc with din=8'hE8 -> inst=8'hE8, irq_req=0.
- Stall/priority: scyc, rcyc and icyc all high with cycle=2 -> cycle stays 2, inst unchanged. rcyc and icyc together -> cycle=0.
- Wrap/error: cycle=7 with icyc -> cycle=0, seq_err=1, and seq_err remains 1 until clr. With SEQ_SINGLE_STEP_EN and step_mode=1, rcyc held 5 clocks -> halted=1 and inst unchanged, until step_req loads din.

Source files
------------

// File: rtl/inst_sequencer.sv
// Instruction register and T-cycle sequencer for the 6502 decoder: owns inst/cycle and latches reset/NMI/IRQ.
// Optional single-step hold of rcyc is compiled in with `define SEQ_SINGLE_STEP_EN.
module inst_sequencer #(
    parameter int                 DATA_W   = 8,
    parameter int                 CYC_W    = 3,
    parameter logic [DATA_W-1:0]  INT_OPC  = '0,
    parameter int                 NMI_SYNC = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] din,
    input  logic              icyc,
    input  logic              rcyc,
    input  logic              scyc,
    input  logic              sinst,
    input  logic              irq_in,
    input  logic              nmi_in,
    input  logic              irq_dis,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic              step_mode,
    input  logic              step_req,
    output logic              halted,
`endif
    output logic [DATA_W-1:0] inst,
    output logic [CYC_W-1:0]  cycle,
    output logic              rst_pend,
    output logic              nmi_pend,
    output logic              irq_req,
    output logic              seq_err
);

    logic [DATA_W-1:0]   inst_reg;
    logic [CYC_W-1:0]    cycle_reg;
    logic                rst_pend_reg;
    logic                nmi_pend_reg;
    logic                irq_req_reg;
    logic                seq_err_reg;
    logic [NMI_SYNC-1:0] nmi_sync_reg;
    logic [NMI_SYNC-1:0] nmi_sync_next;
    logic                nmi_prev_reg;

    logic nmi_sync_out;
    logic nmi_rise;
    logic int_pending;
    logic cycle_terminal;
    logic rcyc_go;
    logic icyc_go;

    // Shift chain for nmi_in; stage 0 takes the raw pin.
    assign nmi_sync_next[0] = nmi_in;
    generate
        for (genvar gi = 1; gi < NMI_SYNC; gi++) begin : g_nmi_sync
            assign nmi_sync_next[gi] = nmi_sync_reg[gi-1];
        end
    endgenerate

    assign nmi_sync_out   = nmi_sync_reg[NMI_SYNC-1];
    assign nmi_rise       = nmi_sync_out & ~nmi_prev_reg;
    assign int_pending    = rst_pend_reg | nmi_pend_reg | irq_req_reg;
    assign cycle_terminal = (cycle_reg == {CYC_W{1'b1}});

`ifdef SEQ_SINGLE_STEP_EN
    logic halted_reg;
    // In step mode an rcyc only proceeds on the clock that also carries step_req.
    assign rcyc_go = ~scyc & rcyc & ~(step_mode & ~step_req);
    assign halted  = halted_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            halted_reg <= 1'b0;
        end else if (~step_mode) begin
            halted_reg <= 1'b0;
        end else if (~scyc & rcyc) begin
            halted_reg <= ~step_req;
        end
    end
`else
    assign rcyc_go = ~scyc & rcyc;
`endif

    assign icyc_go = ~scyc & ~rcyc & icyc;

    always_ff @(posedge clk) begin
        if (clr) begin
            inst_reg     <= INT_OPC;
            cycle_reg    <= '0;
            rst_pend_reg <= 1'b1;
            nmi_pend_reg <= 1'b0;
            irq_req_reg  <= 1'b0;
            seq_err_reg  <= 1'b0;
            nmi_sync_reg <= '0;
            nmi_prev_reg <= 1'b0;
        end else begin
            nmi_sync_reg <= nmi_sync_next;
            nmi_prev_reg <= nmi_sync_out;
            irq_req_reg  <= irq_in & ~irq_dis;

            if (rcyc_go) begin
                cycle_reg <= '0;
                inst_reg  <= int_pending ? INT_OPC : din;
            end else if (icyc_go) begin
                cycle_reg <= cycle_reg + 1'b1;
                if (cycle_terminal) begin
                    seq_err_reg <= 1'b1;
                end
            end

            // sinst retires only the highest-priority source; a fresh NMI edge beats its clear.
            if (sinst & rst_pend_reg) begin
                rst_pend_reg <= 1'b0;
            end
            if (nmi_rise) begin
                nmi_pend_reg <= 1'b1;
            end else if (sinst & ~rst_pend_reg) begin
                nmi_pend_reg <= 1'b0;
            end
        end
    end

    assign inst     = inst_reg;
    assign cycle    = cycle_reg;
    assign rst_pend = rst_pend_reg;
    assign nmi_pend = nmi_pend_reg;
    assign irq_req  = irq_req_reg;
    assign seq_err  = seq_err_reg;

endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer: directed vectors, a rule-level reference model compared every cycle,
// and literal spot checks that pin the model. Optional step-mode vectors run with SEQ_SINGLE_STEP_EN.
module tb_inst_sequencer;
    localparam int DATA_W   = 8;
    localparam int CYC_W    = 3;
    localparam int NMI_SYNC = 2;
    localparam int CYC_MOD  = 1 << CYC_W;

    logic              clk = 1'b0;
    logic              clr = 1'b1;
    logic [DATA_W-1:0] din = '0;
    logic              icyc = 1'b0, rcyc = 1'b0, scyc = 1'b0, sinst = 1'b0;
    logic              irq_in = 1'b0, nmi_in = 1'b0, irq_dis = 1'b0;
    logic [DATA_W-1:0] inst;
    logic [CYC_W-1:0]  cycle;
    logic              rst_pend, nmi_pend, irq_req, seq_err;
`ifdef SEQ_SINGLE_STEP_EN
    logic              step_mode = 1'b0, step_req = 1'b0, halted;
`endif

    int errors = 0;
    int checks = 0;
    int tick_no = 0;
    bit check_en = 1'b0;

    inst_sequencer #(.DATA_W(DATA_W), .CYC_W(CYC_W), .INT_OPC(8'h00), .NMI_SYNC(NMI_SYNC)) dut (
        .clk(clk), .clr(clr), .din(din), .icyc(icyc), .rcyc(rcyc), .scyc(scyc),
        .sinst(sinst), .irq_in(irq_in), .nmi_in(nmi_in), .irq_dis(irq_dis),
`ifdef SEQ_SINGLE_STEP_EN
        .step_mode(step_mode), .step_req(step_req), .halted(halted),
`endif
        .inst(inst), .cycle(cycle), .rst_pend(rst_pend), .nmi_pend(nmi_pend),
        .irq_req(irq_req), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    // Reference model: state the decoder should see, derived from the sequencing rules.
    int m_inst, m_cycle, m_halted;
    bit m_rst, m_nmi, m_irq, m_err;
    bit nmi_seen [0:NMI_SYNC];  // nmi_seen[k]: nmi_in as sampled k+1 edges ago

    always @(posedge clk) begin
        bit old_rst, old_nmi, old_irq, rise, rcyc_acts;
        if (clr) begin
            m_inst = 0; m_cycle = 0; m_rst = 1; m_nmi = 0; m_irq = 0; m_err = 0; m_halted = 0;
            for (int k = 0; k <= NMI_SYNC; k++) nmi_seen[k] = 0;
        end else begin
            old_rst = m_rst; old_nmi = m_nmi; old_irq = m_irq;
            rise = nmi_seen[NMI_SYNC-1] && !nmi_seen[NMI_SYNC];
            rcyc_acts = rcyc && !scyc;
`ifdef SEQ_SINGLE_STEP_EN
            if (!step_mode) m_halted = 0;
            else if (rcyc && !scyc) m_halted = step_req ? 0 : 1;
            if (step_mode && !step_req) rcyc_acts = 0;
`endif
            if (scyc) begin
                // stalled: instruction and cycle frozen
            end else if (rcyc) begin
                if (rcyc_acts) begin
                    m_cycle = 0;
                    m_inst  = (old_rst || old_nmi || old_irq) ? 0 : int'(din);
                end
            end else if (icyc) begin
                if (m_cycle == CYC_MOD - 1) m_err = 1;
                m_cycle = (m_cycle + 1) % CYC_MOD;
            end
            if (sinst && old_rst) m_rst = 0;
            if (rise) m_nmi = 1;
            else if (sinst && !old_rst) m_nmi = 0;
            m_irq = irq_in && !irq_dis;
            for (int k = NMI_SYNC; k > 0; k--) nmi_seen[k] = nmi_seen[k-1];
            nmi_seen[0] = nmi_in;
        end
        check_en = 1'b1;
    end

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (tick %0d)", name, actual, expected, tick_no);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("model_inst", int'(inst), m_inst);
            chk("model_cycle", int'(cycle), m_cycle);
            chk("model_rst_pend", int'(rst_pend), int'(m_rst));
            chk("model_nmi_pend", int'(nmi_pend), int'(m_nmi));
            chk("model_irq_req", int'(irq_req), int'(m_irq));
            chk("model_seq_err", int'(seq_err), int'(m_err));
`ifdef SEQ_SINGLE_STEP_EN
            chk("model_halted", int'(halted), m_halted);
`endif
        end
    end

    task automatic tick(input logic r, input logic i, input logic s, input logic si,
                        input logic [DATA_W-1:0] d);
        rcyc = r; icyc = i; scyc = s; sinst = si; din = d;
        @(posedge clk);
        @(negedge clk);
        tick_no++;
        $display("tick %0d clr=%0b r=%0b i=%0b s=%0b si=%0b din=%h -> inst=%h cycle=%0d rst=%0b nmi=%0b irq=%0b err=%0b",
                 tick_no, clr, r, i, s, si, d, inst, cycle, rst_pend, nmi_pend, irq_req, seq_err);
        rcyc = 0; icyc = 0; scyc = 0; sinst = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        // Reset
        clr = 1; idle(1); clr = 0;
        chk("rst_inst", int'(inst), 'h00);
        chk("rst_cycle", int'(cycle), 0);
        chk("rst_pend_set", int'(rst_pend), 1);
        tick(0, 0, 0, 1, 8'h00);
        chk("sinst_clears_rst", int'(rst_pend), 0);
        for (int k = 0; k < 3; k++) tick(0, 1, 0, 0, 8'h00);
        chk("three_icyc", int'(cycle), 3);
        tick(1, 0, 0, 0, 8'hA9);
        chk("first_fetch_inst", int'(inst), 'hA9);
        chk("first_fetch_cycle", int'(cycle), 0);

        // Opcode fetch with a four-cycle instruction
        tick(1, 0, 0, 0, 8'h6D);
        chk("fetch_6d", int'(inst), 'h6D);
        for (int k = 1; k <= 4; k++) begin
            tick(0, 1, 0, 0, 8'h00);
            chk("fetch_cycle_seq", int'(cycle), k);
        end
        chk("fetch_inst_held", int'(inst), 'h6D);
        tick(1, 0, 0, 0, 8'hEA);
        chk("fetch_ea", int'(inst), 'hEA);
        chk("fetch_ea_cycle", int'(cycle), 0);

        // NMI and IRQ together
        irq_in = 1; irq_dis = 0; nmi_in = 1;
        idle(2);
        chk("nmi_sync_delay", int'(nmi_pend), 0);
        chk("irq_one_clock", int'(irq_req), 1);
        idle(1);
        chk("nmi_latched", int'(nmi_pend), 1);
        tick(1, 0, 0, 0, 8'h55);
        chk("nmi_forces_brk", int'(inst), 'h00);
        tick(0, 0, 0, 1, 8'h00);
        chk("sinst_clears_nmi", int'(nmi_pend), 0);
        chk("irq_survives_sinst", int'(irq_req), 1);
        tick(1, 0, 0, 0, 8'h55);
        chk("irq_forces_brk", int'(inst), 'h00);
        nmi_in = 0;

        // IRQ masked by I flag
        irq_dis = 1;
        idle(1);
        tick(1, 0, 0, 0, 8'hE8);
        chk("masked_inst", int'(inst), 'hE8);
        chk("masked_irq", int'(irq_req), 0);
        irq_in = 0; irq_dis = 0;

        // Stall and request priority
        tick(1, 0, 0, 0, 8'h11);
        tick(0, 1, 0, 0, 8'h00);
        tick(0, 1, 0, 0, 8'h00);
        tick(1, 1, 1, 0, 8'h22);
        chk("stall_cycle", int'(cycle), 2);
        chk("stall_inst", int'(inst), 'h11);
        tick(1, 1, 0, 0, 8'h33);
        chk("rcyc_over_icyc_cycle", int'(cycle), 0);
        chk("rcyc_over_icyc_inst", int'(inst), 'h33);

        // Counter wrap and sticky error
        for (int k = 0; k < 7; k++) tick(0, 1, 0, 0, 8'h00);
        chk("cycle_at_7", int'(cycle), 7);
        chk("no_err_yet", int'(seq_err), 0);
        tick(0, 1, 0, 0, 8'h00);
        chk("wrap_cycle", int'(cycle), 0);
        chk("wrap_err", int'(seq_err), 1);
        chk("wrap_inst_held", int'(inst), 'h33);
        tick(0, 1, 0, 0, 8'h00);
        tick(1, 0, 0, 0, 8'h44);
        chk("err_sticky", int'(seq_err), 1);
        clr = 1; idle(1); clr = 0;
        chk("err_cleared", int'(seq_err), 0);

        // NMI set beats sinst clear on the same clock
        tick(0, 0, 0, 1, 8'h00);
        nmi_in = 1;
        idle(2);
        tick(0, 0, 0, 1, 8'h00);
        chk("nmi_set_wins", int'(nmi_pend), 1);
        tick(0, 0, 0, 1, 8'h00);
        chk("nmi_cleared_later", int'(nmi_pend), 0);
        nmi_in = 0;

        // Reset outranks NMI for sinst
        clr = 1; idle(1); clr = 0;
        nmi_in = 1;
        idle(3);
        tick(0, 0, 0, 1, 8'h00);
        chk("sinst_takes_rst", int'(rst_pend), 0);
        chk("sinst_keeps_nmi", int'(nmi_pend), 1);
        tick(0, 0, 0, 1, 8'h00);
        chk("sinst_then_nmi", int'(nmi_pend), 0);
        nmi_in = 0;

        // Reset mid-instruction
        tick(1, 0, 0, 0, 8'h9A);
        tick(0, 1, 0, 0, 8'h00);
        clr = 1; idle(1); clr = 0;
        chk("mid_rst_inst", int'(inst), 'h00);
        chk("mid_rst_cycle", int'(cycle), 0);

`ifdef SEQ_SINGLE_STEP_EN
        tick(0, 0, 0, 1, 8'h00);
        tick(1, 0, 0, 0, 8'h21);
        step_mode = 1;
        for (int k = 0; k < 5; k++) tick(1, 0, 0, 0, 8'h77);
        chk("step_halted", int'(halted), 1);
        chk("step_inst_held", int'(inst), 'h21);
        step_req = 1;
        tick(1, 0, 0, 0, 8'h77);
        step_req = 0;
        chk("step_loaded", int'(inst), 'h77);
        chk("step_released", int'(halted), 0);
        step_mode = 0;
`endif

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
